// File: rtl/ascon_pkg.sv
// Shared constants, FSM state type and randomness sizing for the masked chi layer.
package ascon_pkg;

  localparam int unsigned ASCON_STATE_W = 320;
  localparam int unsigned ASCON_WORD_W  = 64;
  localparam int unsigned ASCON_NWORDS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } chi_state_e;

  // Fresh random bits consumed by one 5-bit column at masking order d.
  function automatic int unsigned rnd_bits_per_col(input int unsigned d);
    return 5 * d * (d + 1) / 2;
  endfunction

endpackage

// File: rtl/ascon_dom_chi_col.sv
// One 5-bit chi column on D+1 shares: DOM AND terms, register stage, XOR-tree compression.
module ascon_dom_chi_col
  import ascon_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic                              clk,
  input  logic                              en,
  input  logic [(D+1)*ASCON_NWORDS-1:0]     x,
  input  logic [rnd_bits_per_col(D)-1:0]    rnd,
  output logic [(D+1)*ASCON_NWORDS-1:0]     y
);

  localparam int unsigned NS = D + 1;
  localparam int unsigned NP = D * (D + 1) / 2;
  localparam int unsigned NE = NS + 1;

  logic [ASCON_NWORDS-1:0][NS-1:0][NS-1:0] prod_d;
  logic [ASCON_NWORDS-1:0][NS-1:0][NS-1:0] prod_q;
  logic [NS*ASCON_NWORDS-1:0]              x_q;

  // Position of pair (j,k), j<k, in ascending pair order; diagonal maps to 0 (unused).
  function automatic int unsigned pair_index(input int unsigned j, input int unsigned k);
    int unsigned lo;
    int unsigned hi;
    lo = (j < k) ? j : k;
    hi = (j < k) ? k : j;
    if (lo == hi) return 0;
    return lo * NS - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  // Balanced pairwise XOR reduction; an odd last element passes to the next level.
  function automatic logic xor_tree(input logic [NE-1:0] v);
    logic [2*NE-1:0] t;
    logic [2*NE-1:0] nt;
    int unsigned     cnt;
    t   = '0;
    t[NE-1:0] = v;
    cnt = NE;
    for (int unsigned lvl = 0; lvl < NE; lvl++) begin
      nt = '0;
      for (int unsigned k = 0; k < NE; k++) begin
        if (2 * k + 1 < cnt)       nt[k] = t[2*k] ^ t[2*k+1];
        else if (2 * k + 1 == cnt) nt[k] = t[2*k];
      end
      if (cnt > 1) begin
        t   = nt;
        cnt = (cnt + 1) / 2;
      end
    end
    return t[0];
  endfunction

  // DOM partial products: a_j = (NOT on share 0) x_{i+1}, b_k = x_{i+2}; r shared by [j][k] and [k][j].
  always_comb begin
    prod_d = '0;
    for (int unsigned i = 0; i < ASCON_NWORDS; i++) begin
      for (int unsigned j = 0; j < NS; j++) begin
        for (int unsigned k = 0; k < NS; k++) begin
          prod_d[i][j][k] = ((x[j*5 + (i+1)%5] ^ (j == 0)) & x[k*5 + (i+2)%5])
                          ^ ((j != k) ? rnd[i*NP + pair_index(j, k)] : 1'b0);
        end
      end
    end
  end

  // Register stage before compression; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_q <= prod_d;
      x_q    <= x;
    end
  end

  // Share compression: y_s = x_s XOR all products of domain s.
  always_comb begin
    y = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned i = 0; i < ASCON_NWORDS; i++) begin
        y[s*5 + i] = xor_tree({prod_q[i][s], x_q[s*5 + i]});
      end
    end
  end

endmodule

// File: rtl/ascon_chi_layer_dom.sv
// Masked ASCON chi layer: LANES columns per batch through a one-stage DOM pipeline.
module ascon_chi_layer_dom
  import ascon_pkg::*;
#(
  parameter int unsigned D     = 2,
  parameter int unsigned LANES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [(D+1)*ASCON_STATE_W-1:0]        state_in,
  input  logic [LANES*rnd_bits_per_col(D)-1:0]  rnd_in,
  input  logic                                  rnd_valid,
  output logic                                  rnd_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic [(D+1)*ASCON_STATE_W-1:0]        state_out
);

  localparam int unsigned NS   = D + 1;
  localparam int unsigned NB   = ASCON_WORD_W / LANES;
  localparam int unsigned CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RC   = rnd_bits_per_col(D);
  localparam int unsigned CX   = NS * ASCON_NWORDS;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  chi_state_e                    state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic [CW-1:0]                 wb_cnt_q;
  logic                          valid_q;
  logic [NS*ASCON_STATE_W-1:0]   st_q;
  logic                          accept;
  logic                          issue;
  logic                          last_issue;
  logic [LANES-1:0][CX-1:0]      col_x;
  logic [LANES-1:0][CX-1:0]      col_y;

  assign accept     = (state_q == ST_IDLE) && start;
  assign issue      = (state_q == ST_RUN) && rnd_valid;
  assign last_issue = issue && (cnt_q == LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)      state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_FLUSH;
      ST_FLUSH: if (valid_q)    state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Batch counter (saturates at the last batch) and pipeline valid/column tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wb_cnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= issue;
      if (issue) wb_cnt_q <= cnt_q;
      if (accept)                    cnt_q <= '0;
      else if (issue && !last_issue) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Column gather for the current batch; a compare-per-batch mux keeps all bit selects constant.
  always_comb begin
    col_x = '0;
    for (int unsigned bb = 0; bb < NB; bb++) begin
      if (cnt_q == CW'(bb)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          for (int unsigned s = 0; s < NS; s++) begin
            for (int unsigned w = 0; w < ASCON_NWORDS; w++) begin
              col_x[l][s*5 + w] = st_q[s*ASCON_STATE_W + w*ASCON_WORD_W + bb*LANES + l];
            end
          end
        end
      end
    end
  end

  // State register: load on accept, write back the batch tagged at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (accept) begin
      st_q <= state_in;
    end else if (valid_q) begin
      for (int unsigned bb = 0; bb < NB; bb++) begin
        if (wb_cnt_q == CW'(bb)) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned s = 0; s < NS; s++) begin
              for (int unsigned w = 0; w < ASCON_NWORDS; w++) begin
                st_q[s*ASCON_STATE_W + w*ASCON_WORD_W + bb*LANES + l] <= col_y[l][s*5 + w];
              end
            end
          end
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gen_col
    ascon_dom_chi_col #(
      .D(D)
    ) u_col (
      .clk (clk),
      .en  (issue),
      .x   (col_x[l]),
      .rnd (rnd_in[l*RC +: RC]),
      .y   (col_y[l])
    );
  end

  assign rnd_ready = issue;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign state_out = st_q;

endmodule

// File: doc/ascon_chi_layer_dom.md
ASCON_CHI_LAYER_DOM -- requirements
Module: ascon_chi_layer_dom

Interface
REQ-001 SHALL have parameter D, default 2: masking order, giving D+1 shares; legal range 1..4.
REQ-002 SHALL have parameter LANES, default 8: 5-bit chi columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset, declared first and in this order:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
REQ-004 SHALL have the following data and control ports:
- start  in  1  load state_in and begin a layer
- state_in  in  (D+1)*320  shared state; bit index s*320 + w*64 + b = share s, word x_w, bit b
- rnd_in  in  LANES*5*D*(D+1)/2  fresh randomness for one batch
- rnd_valid  in  1  rnd_in usable this cycle
- rnd_ready  out  1  rnd_in consumed this cycle
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse; state_out valid
- state_out  out  (D+1)*320  shared result, same layout as state_in

Function
REQ-005 SHALL compute, per column, y_i = x_i XOR (NOT x_{i+1} AND x_{i+2}), indices mod 5, on shares.
- Only the affine ASCON layers are excluded.
- NOT SHALL be applied to share 0 only, for every D.
REQ-006 SHALL compute each AND with DOM.
- Cross-domain terms (j<k) SHALL each use one fresh bit r.
- The same r SHALL be used in both the [j][k] and [k][j] terms.
- Randomness indexing SHALL be lane-major, then word i, then (j,k) pairs in ascending order.
REQ-007 SHALL register all DOM partial products before share compression (XOR tree). This gives a latency of 1 cycle per batch.
REQ-008 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
- IDLE→RUN: on start; state_in is captured into the internal state register.
- RUN→FLUSH: after the last batch is issued.
- FLUSH→DONE: after the last write-back.
- DONE→IDLE: unconditionally, after one cycle.
REQ-009 SHALL ignore start in any state other than IDLE.
REQ-010 SHALL issue a batch only when in RUN and rnd_valid=1.
- rnd_ready SHALL equal the issue condition (combinational).
- An issued batch covers columns b = c*LANES .. c*LANES+LANES-1, for batch counter c.
REQ-011 SHALL leave the batch counter unchanged in any RUN cycle with rnd_valid=0.
- A batch already in flight SHALL still be written back in that cycle.
REQ-012 SHALL carry a valid bit alongside the register stage.
- Write-back to the state register SHALL occur only when that valid bit is 1.
- Write-back SHALL go to the column indices latched at issue.
REQ-013 SHALL size the batch counter at $clog2(64/LANES) bits, minimum 1. The counter SHALL NOT wrap within a layer.
REQ-014 SHALL assert busy in RUN and FLUSH only.
REQ-015 SHALL assert done only in DONE.
REQ-016 SHALL drive state_out continuously from the state register. Its value SHALL be stable from DONE until the next accepted start.
REQ-017 SHALL give the following timing with rnd_valid held at 1, where N = 64/LANES and the accept cycle is cycle 0:
- batches issue in cycles 1..N;
- done is high in cycle N+2.

Reset
REQ-018 SHALL, on rst_n=0, asynchronously and immediately:
- force the FSM to IDLE;
- clear the state register, batch counter and pipeline valid bit;
- drive busy=0, done=0, rnd_ready=0, state_out=0.
REQ-019 SHALL abort an in-progress layer when reset is asserted mid-operation.
- No write-back SHALL occur after reset.
- After release, a new start SHALL begin from batch 0.
REQ-020 SHALL NOT require a reset on DOM pipeline data registers; only the valid bit is reset.

Structure
REQ-021 SHALL place the following in package ascon_pkg:
- constants ASCON_STATE_W=320, ASCON_WORD_W=64, ASCON_NWORDS=5;
- a typedef for the FSM state enum;
- a function returning the randomness bits required per column, 5*D*(D+1)/2.
REQ-022 SHALL instantiate LANES copies of sub-module ascon_dom_chi_col.
- The sub-module contains one 5-bit column: DOM ANDs, register stage and XOR tree.
- It is parametrised by D.
REQ-023 SHALL implement the XOR-tree reduction as a balanced pairwise tree. The odd element SHALL pass through to the next level.

Verification
REQ-024 D=2, LANES=8, start with all shares 0, rnd_valid=1 → done in cycle 10; recombined output is all 0.
REQ-025 D=2, LANES=8, recombined x0 = all ones and x1..x4 = 0, with random masks → recombined y0 = all ones, y3 = all ones, y1 = y2 = y4 = 0.
REQ-026 D=1, LANES=64, random state, random rnd_in → done in cycle 3; recombined output matches the unmasked chi model; each share individually differs from the unmasked result.
REQ-027 D=2, LANES=8, rnd_valid toggled 1,0,0,1,... → rnd_ready tracks rnd_valid in RUN; exactly 8 issues; result identical to the unstalled run.
REQ-028 rst_n pulsed low in RUN at batch 3 → busy=0 and state_out=0 immediately; a subsequent start with new data yields a correct result.
REQ-029 start held high throughout busy → no restart; done pulses once per accepted start.
